// File: rtl/freoff_ctrl.sv
// Frequency-offset estimate/compensate sequencer: settle/latch P, arm compensator, gate samples, drain.
// Optional macro FREOFF_CTRL_RETRIG_EN: det_stb during SETTLE/ARM restarts the settle phase.
module freoff_ctrl #(
   parameter int SETTLE_LEN = 16,
   parameter int ARM_LAT    = 24,
   parameter int MAX_LEN    = 4095,
   parameter int DRAIN_TO   = 64,
   parameter int CNT_W      = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        det_stb,
   input  logic        frame_end,
   input  logic        stb_in,
   input  logic [22:0] P_Re_in,
   input  logic [22:0] P_Im_in,
   input  logic        comp_out_val,
   output logic        comp_ena,
   output logic [22:0] P_Re,
   output logic [22:0] P_Im,
   output logic        comp_stb,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // state  | meaning
   // IDLE   | waiting for packet detect
   // SETTLE | counting samples while autocorrelation settles
   // ARM    | compensator enabled, waiting out phase-translate latency
   // RUN    | forwarding and counting samples
   // DRAIN  | waiting for compensator outputs to catch up
   // DONE   | one-cycle wrap-up, counters cleared
   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_ARM, S_RUN, S_DRAIN, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
   localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_LAT - 1);
   localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_LEN - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TO - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  scnt_q, scnt_d;
   logic [CNT_W-1:0]  acnt_q, acnt_d;
   logic [CNT_W-1:0]  dcnt_q, dcnt_d;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [22:0]       p_re_q, p_re_d;
   logic [22:0]       p_im_q, p_im_d;
   logic              comp_ena_q, comp_ena_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              smp;
   logic              retrig;

   assign smp = stb_in & ce;

`ifdef FREOFF_CTRL_RETRIG_EN
   assign retrig = det_stb;
`else
   assign retrig = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      acnt_d    = acnt_q;
      dcnt_d    = dcnt_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      p_re_d    = p_re_q;
      p_im_d    = p_im_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      // Compensator outputs can never outnumber samples fed in.
      if ((state_q == S_ARM || state_q == S_RUN || state_q == S_DRAIN) &&
          comp_out_val && (out_cnt_q < in_cnt_q))
         out_cnt_d = out_cnt_q + ONE;

      case (state_q)
         S_IDLE: begin
            if (det_stb) begin
               state_d = S_SETTLE;
               scnt_d  = '0;
            end
         end
         S_SETTLE: begin
            if (retrig) begin
               scnt_d = '0;
            end else if (smp) begin
               if (scnt_q == SETTLE_LAST) begin
                  p_re_d  = P_Re_in;
                  p_im_d  = P_Im_in;
                  acnt_d  = '0;
                  state_d = S_ARM;
               end else begin
                  scnt_d = scnt_q + ONE;
               end
            end
         end
         S_ARM: begin
            if (retrig) begin
               scnt_d  = '0;
               state_d = S_SETTLE;
            end else if (acnt_q == ARM_LAST) begin
               state_d = S_RUN;
            end else begin
               acnt_d = acnt_q + ONE;
            end
         end
         S_RUN: begin
            if (smp)
               in_cnt_d = in_cnt_q + ONE;
            if (frame_end || (smp && in_cnt_q == MAX_LAST)) begin
               dcnt_d  = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_cnt_q == in_cnt_q) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (dcnt_q == DRAIN_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               dcnt_d = dcnt_q + ONE;
            end
         end
         S_DONE: begin
            scnt_d    = '0;
            acnt_d    = '0;
            dcnt_d    = '0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      comp_ena_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         scnt_q     <= '0;
         acnt_q     <= '0;
         dcnt_q     <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         p_re_q     <= '0;
         p_im_q     <= '0;
         comp_ena_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         scnt_q     <= scnt_d;
         acnt_q     <= acnt_d;
         dcnt_q     <= dcnt_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         p_re_q     <= p_re_d;
         p_im_q     <= p_im_d;
         comp_ena_q <= comp_ena_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign comp_ena = comp_ena_q;
   assign P_Re     = p_re_q;
   assign P_Im     = p_im_q;
   assign done     = done_q;
   assign err      = err_q;
   assign busy     = (state_q != S_IDLE);
   assign comp_stb = smp & (state_q == S_RUN);

endmodule

// File: tb/tb_freoff_ctrl.sv
// Directed bench for freoff_ctrl: table of whole frames plus reset, max-length and retrigger sequences.
module tb_freoff_ctrl;

   logic        clk = 1'b0;
   logic        rst, ce, det_stb, frame_end, stb_in, comp_out_val;
   logic [22:0] P_Re_in, P_Im_in;
   logic        comp_ena, comp_stb, busy, done, err;
   logic [22:0] P_Re, P_Im;

   freoff_ctrl dut (
      .clk(clk), .rst(rst), .ce(ce), .det_stb(det_stb), .frame_end(frame_end),
      .stb_in(stb_in), .P_Re_in(P_Re_in), .P_Im_in(P_Im_in),
      .comp_out_val(comp_out_val), .comp_ena(comp_ena), .P_Re(P_Re), .P_Im(P_Im),
      .comp_stb(comp_stb), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      bit          gap;
      int          lat;
      int          nval;
      logic [22:0] p_re;
      logic [22:0] p_im;
      bit          exp_done;
      int          exp_cyc;
   } rec_t;

   rec_t        vec [5];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] pipe;
   int          lat, vals_sent, val_limit, done_cnt, err_cnt;
   logic        last_stb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Compensator model: echoes each forwarded strobe as out_val after lat cycles, up to val_limit.
   task automatic tick();
      logic s;
      #1;
      s = comp_stb;
      comp_out_val = (lat > 0) && pipe[lat-1] && (vals_sent < val_limit);
      @(posedge clk);
      #1;
      if (comp_out_val) vals_sent++;
      pipe     = {pipe[62:0], s};
      last_stb = s;
      done_cnt += int'(done);
      err_cnt  += int'(err);
   endtask

   task automatic start_frame(input logic [22:0] pr, input logic [22:0] pi, input string tag);
      int fwd;
      det_stb = 1'b1;
      tick();
      det_stb = 1'b0;
      chk({tag, "_busy_settle"}, busy, 1);
      for (int i = 0; i < 16; i++) begin
         stb_in  = 1'b1;
         ce      = 1'b1;
         P_Re_in = (i == 15) ? pr : (23'h7FFFFF ^ 23'(i));
         P_Im_in = (i == 15) ? pi : (23'h5A5A5A ^ 23'(i));
         tick();
      end
      chk({tag, "_p_re_latch"}, P_Re, pr);
      chk({tag, "_p_im_latch"}, P_Im, pi);
      chk({tag, "_ena_arm"}, comp_ena, 1);
      P_Re_in = 23'h0;
      P_Im_in = 23'h0;
      fwd = 0;
      for (int j = 0; j < 24; j++) begin
         stb_in = 1'b1;
         tick();
         fwd += int'(last_stb);
      end
      chk({tag, "_arm_no_stb"}, fwd, 0);
      chk({tag, "_p_re_hold"}, P_Re, pr);
   endtask

   task automatic run_frame(input rec_t r, input string tag);
      int fwd, issued, k, cyc;
      pipe = '0; vals_sent = 0; val_limit = r.nval; lat = r.lat;
      done_cnt = 0; err_cnt = 0;
      start_frame(r.p_re, r.p_im, tag);
      fwd = 0; issued = 0; k = 0;
      while (issued < r.n) begin
         ce        = (r.gap && (k % 2 == 1)) ? 1'b0 : 1'b1;
         stb_in    = 1'b1;
         frame_end = ce && (issued == r.n - 1);
         tick();
         fwd += int'(last_stb);
         if (ce) issued++;
         k++;
      end
      if (r.n == 0) begin
         stb_in    = 1'b0;
         frame_end = 1'b1;
         tick();
      end
      frame_end = 1'b0; stb_in = 1'b0; ce = 1'b1;
      chk({tag, "_fwd_cnt"}, fwd, r.n);
      chk({tag, "_ena_drain"}, comp_ena, 1);
      cyc = 0;
      while (done_cnt == 0 && err_cnt == 0 && cyc < 200) begin
         tick();
         cyc++;
      end
      chk({tag, "_end_cycles"}, cyc, r.exp_cyc);
      chk({tag, "_done_cnt"}, done_cnt, int'(r.exp_done));
      chk({tag, "_err_cnt"}, err_cnt, int'(!r.exp_done));
      chk({tag, "_ena_fall"}, comp_ena, 0);
      chk({tag, "_busy_done"}, busy, 1);
      tick();
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_single_pulse"}, done_cnt + err_cnt, 1);
   endtask

   initial begin
      int fwd, cyc;
      vec[0] = '{100, 1'b0, 30, 100, 23'h012345, 23'h054321, 1'b1, 31};
      vec[1] = '{100, 1'b0, 30,  90, 23'h2AAAAA, 23'h155555, 1'b0, 64};
      vec[2] = '{  0, 1'b0,  1,   0, 23'h7FFFFF, 23'h000001, 1'b1,  1};
      vec[3] = '{  5, 1'b0,  3,   5, 23'h400000, 23'h3FFFFF, 1'b1,  4};
      vec[4] = '{ 20, 1'b1,  4,  20, 23'h0F0F0F, 23'h70F0F0, 1'b1,  5};

      rst = 1'b1; ce = 1'b0; det_stb = 1'b0; frame_end = 1'b0; stb_in = 1'b0;
      comp_out_val = 1'b0; P_Re_in = '0; P_Im_in = '0;
      pipe = '0; lat = 1; vals_sent = 0; val_limit = 0; done_cnt = 0; err_cnt = 0;
      last_stb = 1'b0;

      tick(); tick();
      chk("rst_outputs", {comp_ena, comp_stb, busy, done, err}, 0);
      chk("rst_p", {P_Re, P_Im}, 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      for (int v = 0; v < 5; v++)
         run_frame(vec[v], $sformatf("vec%0d", v));

      // Frame with no frame_end: RUN must stop at MAX_LEN forwarded samples.
      pipe = '0; vals_sent = 0; val_limit = 0; lat = 1; done_cnt = 0; err_cnt = 0;
      start_frame(23'h111111, 23'h222222, "max");
      fwd = 0;
      stb_in = 1'b1; ce = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (!last_stb) break;
         fwd++;
      end
      stb_in = 1'b0;
      chk("max_fwd", fwd, 4095);
      cyc = 1;
      while (done_cnt == 0 && err_cnt == 0 && cyc < 200) begin
         tick();
         cyc++;
      end
      chk("max_err_cycle", cyc, 64);
      chk("max_err_cnt", err_cnt, 1);
      chk("max_done_cnt", done_cnt, 0);
      tick();

      // Reset in the middle of RUN aborts without a completion pulse.
      pipe = '0; vals_sent = 0; val_limit = 0; done_cnt = 0; err_cnt = 0;
      start_frame(23'h333333, 23'h444444, "abort");
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      chk("abort_outputs", {comp_ena, comp_stb, busy, done, err}, 0);
      chk("abort_p", {P_Re, P_Im}, 0);
      rst = 1'b0; stb_in = 1'b0;
      for (int i = 0; i < 80; i++) tick();
      chk("abort_no_pulse", done_cnt + err_cnt, 0);
      run_frame(vec[0], "after_abort");

      // Second det_stb after 8 settle samples.
      det_stb = 1'b1;
      tick();
      det_stb = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         stb_in = 1'b1; ce = 1'b1; P_Re_in = 23'h100 + 23'(k); P_Im_in = 23'h200 + 23'(k);
         tick();
      end
      stb_in = 1'b0; det_stb = 1'b1;
      tick();
      det_stb = 1'b0;
      for (int k = 9; k <= 30; k++) begin
         stb_in = 1'b1; P_Re_in = 23'h100 + 23'(k); P_Im_in = 23'h200 + 23'(k);
         tick();
      end
      stb_in = 1'b0;
`ifdef FREOFF_CTRL_RETRIG_EN
      chk("retrig_p_re", P_Re, 23'h118);
      chk("retrig_p_im", P_Im, 23'h218);
`else
      chk("retrig_p_re", P_Re, 23'h110);
      chk("retrig_p_im", P_Im, 23'h210);
`endif
      chk("retrig_ena", comp_ena, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
